// File: rtl/aes_key_expansion.sv
// Iterative AES-128 key schedule: emits round keys 0..10 one per valid/ready handshake,
// deriving each key from the previous one instead of storing the full schedule.
module aes_key_expansion #(
   parameter int NUM_ROUNDS = 10,
   parameter int KEY_W      = 128
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_key_start,
   input  logic [KEY_W-1:0] i_key,
   output logic [KEY_W-1:0] o_round_key,
   output logic [3:0]       o_round_num,
   output logic             o_round_key_valid,
   input  logic             i_round_key_ready,
   output logic             o_busy,
   output logic             o_done
);

   if (NUM_ROUNDS != 10 || KEY_W != 128) begin : g_bad_param
      $error("aes_key_expansion supports only AES-128 (NUM_ROUNDS=10, KEY_W=128)");
   end

   // Forward S-box, byte x at bits [2047-8x -: 8]
   localparam logic [2047:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
   };

   typedef enum logic [1:0] {S_IDLE, S_EMIT, S_DONE} state_t;

   state_t           state_q, state_d;
   logic [KEY_W-1:0] key_q, key_d;
   logic [3:0]       num_q, num_d;
   logic             valid_q, valid_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [7:0]       rcon_q, rcon_d;
   logic             accept;

   function automatic logic [7:0] sbox(input logic [7:0] x);
      return SBOX[8*(255 - int'(x)) +: 8];
   endfunction

   // Multiply by x in GF(2^8) modulo 0x11b; walks Rcon 01..80 then wraps to 1b, 36
   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [KEY_W-1:0] next_key(input logic [KEY_W-1:0] k,
                                                 input logic [7:0] rc);
      logic [31:0] w3, t, n0, n1, n2, n3;
      w3 = k[31:0];
      t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^ {rc, 24'h0};
      n0 = k[127:96] ^ t;
      n1 = k[95:64]  ^ n0;
      n2 = k[63:32]  ^ n1;
      n3 = w3        ^ n2;
      return {n0, n1, n2, n3};
   endfunction

   assign accept = valid_q & i_round_key_ready;

   always_comb begin
      state_d = state_q;
      key_d   = key_q;
      num_d   = num_q;
      valid_d = valid_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      rcon_d  = rcon_q;
      case (state_q)
         S_IDLE: begin
            if (i_key_start) begin
               key_d   = i_key;
               num_d   = 4'd0;
               valid_d = 1'b1;
               busy_d  = 1'b1;
               state_d = S_EMIT;
            end
         end
         S_EMIT: begin
            if (accept) begin
               if (num_q == 4'(NUM_ROUNDS)) begin
                  valid_d = 1'b0;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  state_d = S_DONE;
               end else begin
                  key_d  = next_key(key_q, rcon_q);
                  num_d  = num_q + 4'd1;
                  rcon_d = xtime(rcon_q);
               end
            end
         end
         S_DONE: begin
            // Key and round number stay on round 10 for the consumer's benefit
            rcon_d  = 8'h01;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         key_q   <= '0;
         num_q   <= 4'd0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         rcon_q  <= 8'h01;
      end else begin
         state_q <= state_d;
         key_q   <= key_d;
         num_q   <= num_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         rcon_q  <= rcon_d;
      end
   end

   assign o_round_key       = key_q;
   assign o_round_num       = num_q;
   assign o_round_key_valid = valid_q;
   assign o_busy            = busy_q;
   assign o_done            = done_q;

endmodule
